// File: rtl/mcla_pipe_addsub.sv
// Pipelined add/sub: segment k of the operands is summed by a grouped carry-lookahead in rank k.
// Latency STAGES cycles, 1 beat/cycle; a stalled output freezes every rank (in_ready = !out_valid | out_ready).
module mcla_pipe_addsub #(
   parameter int WIDTH  = 24,
   parameter int BLK    = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   s,
   output logic             ovf
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int NGRP = SEG / BLK;

   if (STAGES < 1 || BLK < 1 || (WIDTH % (BLK * STAGES)) != 0) begin : g_param_check
      $error("mcla_pipe_addsub: WIDTH must be a multiple of BLK*STAGES");
   end

   // One pipeline slot: the operands travel whole so the top rank can form ovf,
   // sum holds the segments finished so far, cy is the carry into the next segment.
   typedef struct packed {
      logic             vld;
      logic             cy;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] sum;
   } rank_t;

   rank_t rank_in [STAGES];
   rank_t rank_d  [STAGES];
   rank_t rank_q  [STAGES];
   logic  [SEG:0] seg_res [STAGES];
   logic  ovf_d;
   logic  ovf_q;
   logic  advance;

   // Returns {carry_out, sum}: group generate/propagate per BLK bits, then
   // lookahead carries between groups, then ripple inside each group.
   function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                            input logic [SEG-1:0] y,
                                            input logic           c0);
      logic [SEG-1:0]  g;
      logic [SEG-1:0]  p;
      logic [SEG-1:0]  c;
      logic [NGRP-1:0] grp_g;
      logic [NGRP-1:0] grp_p;
      logic [NGRP:0]   grp_c;
      g = x & y;
      p = x ^ y;
      for (int j = 0; j < NGRP; j++) begin
         grp_g[j] = 1'b0;
         grp_p[j] = 1'b1;
         for (int i = 0; i < BLK; i++) begin
            grp_g[j] = g[j*BLK+i] | (p[j*BLK+i] & grp_g[j]);
            grp_p[j] = grp_p[j] & p[j*BLK+i];
         end
      end
      grp_c[0] = c0;
      for (int j = 0; j < NGRP; j++) begin
         grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
      end
      for (int j = 0; j < NGRP; j++) begin
         c[j*BLK] = grp_c[j];
         for (int i = 1; i < BLK; i++) begin
            c[j*BLK+i] = g[j*BLK+i-1] | (p[j*BLK+i-1] & c[j*BLK+i-1]);
         end
      end
      return {grp_c[NGRP], p ^ c};
   endfunction

   assign advance   = !rank_q[STAGES-1].vld || out_ready;
   assign in_ready  = advance;
   assign out_valid = rank_q[STAGES-1].vld;
   assign s         = {rank_q[STAGES-1].cy, rank_q[STAGES-1].sum};
   assign ovf       = ovf_q;

   always_comb begin
      rank_in[0].vld = in_valid;
      rank_in[0].cy  = sub ? 1'b1 : cin;
      rank_in[0].a   = a;
      rank_in[0].b   = sub ? ~b : b;
      rank_in[0].sum = '0;
      for (int k = 1; k < STAGES; k++) begin
         rank_in[k] = rank_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         seg_res[k] = cla_seg(rank_in[k].a[k*SEG +: SEG], rank_in[k].b[k*SEG +: SEG], rank_in[k].cy);
         rank_d[k]  = rank_in[k];
         rank_d[k].sum[k*SEG +: SEG] = seg_res[k][SEG-1:0];
         rank_d[k].cy = seg_res[k][SEG];
      end
      ovf_d = (rank_in[STAGES-1].a[WIDTH-1] == rank_in[STAGES-1].b[WIDTH-1]) &&
              (rank_d[STAGES-1].sum[WIDTH-1] != rank_in[STAGES-1].a[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            rank_q[k] <= '0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            rank_q[k] <= rank_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_mcla_pipe_addsub.sv
// Bench for mcla_pipe_addsub (24/4/2): directed corner cases, backpressure, reset flush,
// and a random stream scored against an integer-arithmetic reference queue.
module tb_mcla_pipe_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] a;
   logic [23:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] s;
   logic        ovf;

   int          n_chk = 0;
   int          n_bad = 0;
   int          n_out = 0;
   logic [25:0] exp_q [$];
   logic        held_vld = 1'b0;
   logic [24:0] held_s;
   logic        held_ovf;

   always #5 clk = ~clk;

   mcla_pipe_addsub #(.WIDTH(24), .BLK(4), .STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .ovf       (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic; overflow = signed result outside 24-bit range.
   function automatic logic [25:0] ref_sum(input logic [23:0] x, input logic [23:0] y,
                                           input logic ci, input logic sb);
      longint ux, uy, sx, sy, us, ss;
      logic   o;
      logic [63:0] u64;
      ux = longint'(x);
      uy = longint'(y);
      sx = x[23] ? ux - 16777216 : ux;
      sy = y[23] ? uy - 16777216 : uy;
      if (sb) begin
         us = ux + 16777216 - uy;
         ss = sx - sy;
      end else begin
         us = ux + uy + longint'(ci);
         ss = sx + sy + longint'(ci);
      end
      o   = (ss > 8388607) || (ss < -8388608);
      u64 = 64'(us);
      return {o, u64[24:0]};
   endfunction

   function automatic logic [23:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 24'hFFFFFF;
         1:       return 24'h7FFFFF;
         2:       return 24'h800000;
         3:       return 24'h000000;
         default: return 24'($urandom);
      endcase
   endfunction

   task automatic step(input logic iv, input logic [23:0] ia, input logic [23:0] ib,
                       input logic ic, input logic isb, input logic ordy,
                       output logic acc, output logic ov, output logic [24:0] os, output logic oo);
      logic [25:0] e;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = isb;
      out_ready = ordy;
      #1;
      ov  = out_valid;
      os  = s;
      oo  = ovf;
      acc = iv && in_ready;
      chk("in_ready", 32'(in_ready), 32'(!out_valid || ordy));
      if (held_vld) begin
         chk("hold_vld", 32'(out_valid), 32'd1);
         chk("hold_s", 32'(s), 32'(held_s));
         chk("hold_ovf", 32'(ovf), 32'(held_ovf));
      end
      held_vld = out_valid && !ordy;
      held_s   = s;
      held_ovf = ovf;
      if (out_valid && ordy) begin
         if (exp_q.size() == 0) begin
            chk("extra_beat", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("s", 32'(s), 32'(e[24:0]));
            chk("ovf", 32'(ovf), 32'(e[25]));
            n_out++;
         end
      end
      if (acc) exp_q.push_back(ref_sum(ia, ib, ic, isb));
      @(posedge clk);
   endtask

   task automatic dir(input string tag, input logic [23:0] ia, input logic [23:0] ib,
                      input logic ic, input logic isb, input logic [24:0] es, input logic eo);
      logic        acc, ov1, ov2, o1, oo;
      logic [24:0] s1, os;
      step(1'b1, ia, ib, ic, isb, 1'b1, acc, ov1, s1, o1);
      chk({tag, "_acc"}, 32'(acc), 32'd1);
      step(1'b0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b1, acc, ov1, s1, o1);
      step(1'b0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b1, acc, ov2, os, oo);
      chk({tag, "_lat1"}, 32'(ov1), 32'd0);
      chk({tag, "_lat2"}, 32'(ov2), 32'd1);
      chk({tag, "_s"}, 32'(os), 32'(es));
      chk({tag, "_ovf"}, 32'(oo), 32'(eo));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic        acc, ov, oo;
      logic [24:0] os;
      int          nb, ia;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      dir("carry_chain", 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 25'h1000000, 1'b0);
      dir("carry_cin",   24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 25'h1000000, 1'b0);
      dir("sub_borrow",  24'h000005, 24'h000007, 1'b0, 1'b1, 25'h0FFFFFE, 1'b0);
      dir("sub_noborrow",24'h000007, 24'h000005, 1'b1, 1'b1, 25'h1000002, 1'b0);
      dir("ovf_add",     24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 25'h0800000, 1'b1);
      dir("ovf_sub",     24'h800000, 24'h000001, 1'b0, 1'b1, 25'h17FFFFF, 1'b1);

      // Backpressure: 8 beats, out_ready low during cycles 3..5.
      nb = n_out;
      ia = 0;
      for (int c = 0; c < 20; c++) begin
         step(ia < 8, 24'(ia), 24'(ia << 12), 1'b0, 1'b0, !(c >= 3 && c <= 5), acc, ov, os, oo);
         if (acc) ia++;
      end
      chk("bp_accepted", 32'(ia), 32'd8);
      chk("bp_emitted", 32'(n_out - nb), 32'd8);

      // Reset with two beats in flight: both must vanish.
      step(1'b1, 24'h123456, 24'h000111, 1'b0, 1'b0, 1'b1, acc, ov, os, oo);
      step(1'b1, 24'h654321, 24'h000222, 1'b0, 1'b0, 1'b1, acc, ov, os, oo);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_s", 32'(s), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      held_vld = 1'b0;
      dir("post_rst", 24'h000010, 24'h000020, 1'b1, 1'b0, 25'h0000031, 1'b0);

      for (int n = 0; n < 10000; n++) begin
         step($urandom_range(0, 3) != 0, pick_operand(), pick_operand(), 1'($urandom),
              1'($urandom), $urandom_range(0, 3) != 0, acc, ov, os, oo);
      end
      for (int d = 0; d < 10 && exp_q.size() > 0; d++) begin
         step(1'b0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b1, acc, ov, os, oo);
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
